// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt dispatch scheduler.
package irq_pkg;

  localparam int unsigned N_IRQ_DEFAULT = 8;
  localparam int unsigned ID_W          = $clog2(N_IRQ_DEFAULT);

  // 2-bit priority level; 0 is the most urgent.
  typedef logic [1:0] prio_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_rr_pick.sv
// Combinational winner select: lowest priority level wins, ties go to the
// first candidate found searching upward from ptr + 1 (mod N).
module irq_rr_pick
  import irq_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned ID_W = 3
) (
  input  logic [N-1:0]    cand,
  input  logic [2*N-1:0]  prio,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  int unsigned idx;
  prio_t       p;
  prio_t       best;

  // Rotating scan; strict less-than keeps the earliest tied line in rotation order.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    best  = '1;
    idx   = 0;
    p     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + 32'd1 + k) % N;
      p   = prio_t'(prio[2*idx +: 2]);
      if (cand[idx] && (!valid || (p < best))) begin
        valid = 1'b1;
        best  = p;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/irq_dispatch_sched.sv
// Interrupt dispatcher: latches request edges, arbitrates by priority with
// round-robin tie break, and runs an offer / ack / eoi handshake.
module irq_dispatch_sched
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IRQ-1:0]         irq_req,
  input  logic [N_IRQ-1:0]         irq_mask,
  input  logic [2*N_IRQ-1:0]       prio_cfg,
  input  logic                     irq_ack,
  input  logic                     irq_eoi,
  output logic                     irq_out,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic [N_IRQ-1:0]         pending,
  output logic [N_IRQ-1:0]         in_service,
  output logic                     timeout_err
);

  localparam int unsigned IW    = $clog2(N_IRQ);
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t           state;
  logic [N_IRQ-1:0] req_q;
  logic [N_IRQ-1:0] req_qq;
  logic [IW-1:0]    rr_ptr;
  logic [CNT_W-1:0] tmo_cnt;

  logic [N_IRQ-1:0] rise_c;
  logic [N_IRQ-1:0] id_onehot_c;
  logic [N_IRQ-1:0] clr_c;
  logic [IW-1:0]    win_id_c;
  logic             win_valid_c;

  assign rise_c      = req_q & ~req_qq;
  assign id_onehot_c = N_IRQ'(1) << irq_id;
  assign clr_c       = ((state == OFFER) && irq_ack) ? id_onehot_c : '0;

  irq_rr_pick #(
    .N    (N_IRQ),
    .ID_W (IW)
  ) u_pick (
    .cand  (pending & ~irq_mask),
    .prio  (prio_cfg),
    .ptr   (rr_ptr),
    .id    (win_id_c),
    .valid (win_valid_c)
  );

  // Edge capture, pending bookkeeping and the offer/service state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= irq_req;
      req_qq      <= irq_req;
      pending     <= '0;
      in_service  <= '0;
      irq_out     <= 1'b0;
      irq_id      <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
    end else begin
      req_q       <= irq_req;
      req_qq      <= req_q;
      timeout_err <= 1'b0;
      // A new edge on the line being acked wins over the clear.
      pending     <= (pending & ~clr_c) | rise_c;
      case (state)
        IDLE: begin
          if (win_valid_c) begin
            state   <= OFFER;
            irq_out <= 1'b1;
            irq_id  <= win_id_c;
            tmo_cnt <= '0;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            state      <= SERVICE;
            in_service <= id_onehot_c;
            irq_out    <= 1'b0;
            rr_ptr     <= irq_id;
          end else if (irq_mask[irq_id]) begin
            state   <= IDLE;
            irq_out <= 1'b0;
          end else if (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state       <= IDLE;
            irq_out     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch_sched.sv
// Directed bench for irq_dispatch_sched with hand-computed expectations.
module tb_irq_dispatch_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_req;
  logic [7:0] irq_mask;
  logic [15:0] prio_cfg;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_out;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_dispatch_sched #(.N_IRQ(8), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_req     (irq_req),
    .irq_mask    (irq_mask),
    .prio_cfg    (prio_cfg),
    .irq_ack     (irq_ack),
    .irq_eoi     (irq_eoi),
    .irq_out     (irq_out),
    .irq_id      (irq_id),
    .pending     (pending),
    .in_service  (in_service),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick until an offer appears (bounded), then check the offered id.
  task automatic wait_offer(input string tag, input logic [2:0] exp_id);
    for (int i = 0; i < 6; i++) begin
      if (irq_out === 1'b1) break;
      tick();
    end
    chk({tag, "_out"}, 32'(irq_out), 32'd1);
    chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  // Accept the current offer and finish it with eoi.
  task automatic serve(input string tag, input logic [2:0] id);
    logic [7:0] oh;
    oh = 8'h01 << id;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk({tag, "_insvc"}, 32'(in_service), 32'(oh));
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    chk({tag, "_eoi"}, 32'(in_service), 32'd0);
  endtask

  initial begin
    rst = 1'b1; irq_req = '0; irq_mask = '0; prio_cfg = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out", 32'(irq_out), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // Ack while idle does nothing.
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("idle_ack", 32'(in_service), 32'd0);

    // Single line 3: latency and handshake.
    irq_req = 8'h08;
    tick();
    chk("l3_e1_pend", 32'(pending), 32'd0);
    chk("l3_e1_out", 32'(irq_out), 32'd0);
    tick();
    chk("l3_e2_pend", 32'(pending), 32'h08);
    chk("l3_e2_out", 32'(irq_out), 32'd0);
    tick();
    chk("l3_e3_out", 32'(irq_out), 32'd1);
    chk("l3_e3_id", 32'(irq_id), 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("l3_insvc", 32'(in_service), 32'h08);
    chk("l3_pend_clr", 32'(pending), 32'd0);
    chk("l3_out_drop", 32'(irq_out), 32'd0);
    irq_eoi = 1'b1; irq_req = '0; tick(); irq_eoi = 1'b0;
    chk("l3_eoi", 32'(in_service), 32'd0);
    chk("l3_id_hold", 32'(irq_id), 32'd3);

    // Lines 2 and 5 together, line 5 more urgent.
    prio_cfg = 16'h0430;  // line2 = 3, line5 = 1
    irq_req = 8'h24;
    wait_offer("pr_first", 3'd5);
    serve("pr_5", 3'd5);
    chk("pr_gap", 32'(irq_out), 32'd0);
    wait_offer("pr_second", 3'd2);
    irq_req = '0;
    serve("pr_2", 3'd2);

    // Round-robin among equal priorities from a fresh pointer.
    prio_cfg = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    irq_req = 8'h52;
    wait_offer("rr_a", 3'd1);
    irq_ack = 1'b1; irq_req = '0; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; irq_req = 8'h02; tick(); irq_eoi = 1'b0;
    wait_offer("rr_b", 3'd4);
    serve("rr_b", 3'd4);
    wait_offer("rr_c", 3'd6);
    serve("rr_c", 3'd6);
    wait_offer("rr_d", 3'd1);
    irq_req = '0;
    serve("rr_d", 3'd1);

    // Acknowledge timeout on line 0.
    irq_req = 8'h01;
    wait_offer("tmo_off", 3'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_pre_out", 32'(irq_out), 32'd1);
    chk("tmo_pre_err", 32'(timeout_err), 32'd0);
    tick();
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_out", 32'(irq_out), 32'd0);
    chk("tmo_pend", 32'(pending), 32'h01);
    tick();
    chk("tmo_err_end", 32'(timeout_err), 32'd0);
    chk("tmo_reoffer", 32'(irq_out), 32'd1);
    chk("tmo_reid", 32'(irq_id), 32'd0);
    irq_req = '0;
    serve("tmo", 3'd0);

    // Mask the offered line, then unmask; finish with ack+eoi together.
    irq_req = 8'h80;
    wait_offer("msk_off", 3'd7);
    irq_mask = 8'h80;
    tick();
    chk("msk_out", 32'(irq_out), 32'd0);
    chk("msk_err", 32'(timeout_err), 32'd0);
    chk("msk_pend", 32'(pending), 32'h80);
    tick();
    chk("msk_hold", 32'(irq_out), 32'd0);
    irq_mask = '0;
    tick();
    chk("msk_reoffer", 32'(irq_out), 32'd1);
    chk("msk_reid", 32'(irq_id), 32'd7);
    irq_ack = 1'b1; irq_eoi = 1'b1; irq_req = '0; tick();
    irq_ack = 1'b0; irq_eoi = 1'b0;
    chk("ackeoi_insvc", 32'(in_service), 32'h80);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("ackeoi_done", 32'(in_service), 32'd0);

    // New edge on line 3 coincident with its ack clear; re-offered after eoi.
    irq_req = 8'h08;
    wait_offer("co_off", 3'd3);
    irq_req = '0;
    tick(); tick();
    irq_req = 8'h08;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("co_insvc", 32'(in_service), 32'h08);
    chk("co_pend", 32'(pending), 32'h08);
    irq_eoi = 1'b1; irq_req = '0; tick(); irq_eoi = 1'b0;
    wait_offer("co_reoff", 3'd3);
    serve("co", 3'd3);

    // Line 0 held across reset produces no edge.
    irq_req = 8'h01;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("hold_out", 32'(irq_out), 32'd0);
    chk("hold_pend", 32'(pending), 32'd0);

    // Reset in the middle of service.
    irq_req = 8'h05;
    wait_offer("rs_off", 3'd2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("rs_insvc", 32'(in_service), 32'h04);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_out", 32'(irq_out), 32'd0);
    chk("rs_id", 32'(irq_id), 32'd0);
    chk("rs_pend", 32'(pending), 32'd0);
    chk("rs_insvc0", 32'(in_service), 32'd0);
    chk("rs_tmo", 32'(timeout_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_dispatch_sched.md
IRQ_DISPATCH_SCHED -- requirements
Module: irq_dispatch_sched

Interface
REQ-001 Parameter N_IRQ, default 8, SHALL set the number of interrupt lines; ID_W = $clog2(N_IRQ).
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of cycles an offer waits for acknowledge.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 irq_req  input  N_IRQ  level request lines, one per source.
REQ-007 irq_mask  input  N_IRQ  1 = line masked, excluded from arbitration.
REQ-008 prio_cfg  input  2*N_IRQ  2-bit level per line at bits [2i+1:2i]; 0 = highest.
REQ-009 irq_ack  input  1  processor accepts the offered interrupt.
REQ-010 irq_eoi  input  1  processor signals end of interrupt service.
REQ-011 irq_out  output  1  interrupt offered to processor.
REQ-012 irq_id  output  ID_W  index of offered or in-service line.
REQ-013 pending  output  N_IRQ  latched pending bits.
REQ-014 in_service  output  N_IRQ  one-hot in-service line, or zero.
REQ-015 timeout_err  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-016 A 0->1 transition of irq_req[i] between consecutive clock samples SHALL set pending[i] at the next edge; a held level or a repeat edge while pending[i] is set SHALL have no further effect.
REQ-017 The candidate set SHALL be pending & ~irq_mask.
REQ-018 The winner SHALL be the candidate with the lowest prio_cfg value; ties SHALL be broken round-robin, searching upward from (last granted id + 1) mod N_IRQ.
REQ-019 The FSM SHALL have states IDLE, OFFER and SERVICE.
REQ-020 IDLE->OFFER SHALL occur on the first edge at which the candidate set is non-zero; irq_out=1 and irq_id=winner SHALL be registered on that edge and held frozen throughout OFFER.
REQ-021 Latency SHALL be 2 cycles from the rising-edge sample of irq_req to irq_out=1 when the FSM is idle.
REQ-022 OFFER with irq_ack=1 SHALL cause the following at the next edge: state->SERVICE, pending[id] cleared, in_service[id] set, irq_out=0, and the round-robin pointer updated to id.
REQ-023 OFFER without irq_ack for ACK_TIMEOUT consecutive cycles SHALL cause timeout_err=1 for one cycle, irq_out=0 and state->IDLE, with pending[id] retained.
REQ-024 If the offered line becomes masked during OFFER and irq_ack=0, the block SHALL return to IDLE with irq_out=0 at the next edge, pending retained and no error.
REQ-025 SERVICE with irq_eoi=1 SHALL clear in_service and move to IDLE at the next edge; irq_id SHALL hold its value until the next offer.
REQ-026 irq_ack outside OFFER and irq_eoi outside SERVICE SHALL be ignored; if ack and eoi are asserted together in OFFER, ack SHALL be honoured and eoi ignored.
REQ-027 An edge on line i coincident with the ack clear of line i SHALL leave pending[i]=1, so the set wins.
REQ-028 An edge on the in-service line SHALL set its pending bit, which is re-offered after eoi; there SHALL be no nesting or preemption.
REQ-029 prio_cfg and irq_mask changes SHALL affect arbitration from the next IDLE decision only.

Reset
REQ-030 During rst, the FSM SHALL enter IDLE and irq_out, irq_id, pending, in_service, timeout_err, the round-robin pointer and the timeout counter SHALL all be 0.
REQ-031 During rst, the edge-detect register SHALL load irq_req so that lines held high across reset release generate no edge.
REQ-032 Asserting rst in OFFER or SERVICE SHALL abort the operation with no timeout_err pulse.

Structure
REQ-033 Package irq_pkg SHALL hold the state enum (IDLE/OFFER/SERVICE), the N_IRQ default, ID_W and the prio_t 2-bit typedef.
REQ-034 Sub-module irq_rr_pick SHALL be combinational: candidate vector, priority vector and rr pointer in, winner id and valid out.

Verification
REQ-035 Rise on irq_req[3] only -> irq_out=1, irq_id=3 two cycles later; ack -> in_service=8'h08; eoi -> in_service=0.
REQ-036 Simultaneous rise on lines 2 and 5 with prio 2=3 and prio 5=1 -> id 5 offered first, then id 2 after eoi.
REQ-037 Lines 1, 4 and 6 all at prio 0 and re-raised after each service -> grant order 1, 4, 6, 1 (round-robin).
REQ-038 No ack for 16 cycles -> timeout_err pulse, pending bit kept, line re-offered next cycle.
REQ-039 Mask the offered line during OFFER -> irq_out drops next cycle and no error; unmask -> re-offered.
REQ-040 Line 0 held high through reset -> no offer; rst mid-SERVICE -> all outputs 0 next edge.
